adder_exhaustive_checker: RTL and testbench
===========================================

Name: adder_exhaustive_checker

Overview:
- Synthesizable response-side companion to the adder stimulus benches: drives every input combination into an external W-bit adder DUT and waits a programmable settle time.
- Samples the DUT's sum/carry, compares against an internal golden model and reports pass/fail, error count and first failing vector.
- Used on-board and in simulation to self-check the ha/fa/ripple adders without a waveform viewer.

Parameters:
- WIDTH, 1, operand width of DUT adder (1 = single full adder).
- SETTLE_CYCLES, 2, clock cycles a vector is held before sampling; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled only in IDLE or DONE.
- a  output  WIDTH  operand A to DUT.
- b  output  WIDTH  operand B to DUT.
- ci  output  1  carry-in to DUT.
- dut_s  input  WIDTH  DUT sum.
- dut_co  input  1  DUT carry-out.
- busy  output  1  high during a sweep.
- done  output  1  high from end of sweep until next accepted start.
- pass  output  1  valid when done; 1 iff err_count == 0.
- err_count  output  2*WIDTH+2  number of mismatching vectors.
- first_fail  output  2*WIDTH+1  index of first mismatching vector.

Behaviour:
- VW = 2*WIDTH+1 and NV = 2^VW. The vector index vec[VW-1:0] maps as {a,b,ci}: ci is the LSB, a the MSBs. Order is ascending 0..NV-1.
- Reset (async, rst_n low) forces:
  - state IDLE;
  - a, b, ci, err_count, first_fail to 0;
  - busy, done, pass to 0;
  - settle counter to 0.
  - Reset mid-sweep abandons the sweep with no partial result.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE: if start=1 at an edge, go to SETTLE; vec=0; clear err_count, first_fail, pass; busy=1.
  - SETTLE: hold vec for SETTLE_CYCLES cycles, counting 0..SETTLE_CYCLES-1, then go to CHECK.
  - CHECK (1 cycle): at the leaving edge compare {dut_co,dut_s} against a+b+ci, computed in WIDTH+1 bits.
    - On mismatch: err_count++; if err_count was 0, first_fail=vec.
    - If vec==NV-1: go to DONE, busy=0, done=1, pass=(final err_count==0).
    - Else vec++ and go to SETTLE.
  - DONE: hold all results. a, b, ci keep the last vector (all ones). start=1 restarts exactly as from IDLE and clears done at that edge.
- start while busy is ignored. start held high continuously re-runs the sweep back-to-back, with one DONE cycle between runs.
- Latency: start accepted at edge k gives done high after edge k + NV*(SETTLE_CYCLES+1). Example: WIDTH=1, SETTLE=2 gives 24 cycles.
- err_count cannot overflow, since its maximum is NV and it has VW+1 bits.
- DUT inputs are sampled only in CHECK; glitches during SETTLE are irrelevant.
- All outputs are registered; there is no combinational path from dut_s/dut_co to any output.

Decomposition:
- Package adder_chk_pkg:
  - state encoding localparams (IDLE=0, SETTLE=1, CHECK=2, DONE=3);
  - a constant function for VW;
  - a settle-counter width helper (clog2).
- One sub-module, adder_ref_model: purely combinational golden {co,s}=a+b+ci, parameterized by WIDTH. It is instantiated once in the checker and reused by benches.

Test Plan:
- Correct fa as DUT, WIDTH=1, SETTLE=2, start pulsed at cycle 5:
  - busy high for 24 cycles, then done=1, pass=1, err_count=0, first_fail=0;
  - a/b/ci sequence 000..111.
- dut_co stuck at 0 -> mismatches at vectors 3,5,6,7 -> err_count=4, first_fail=3, pass=0.
- dut_s inverted -> err_count=8, first_fail=0, pass=0; restart from DONE with a correct DUT -> err_count=0, pass=1.
- rst_n low asynchronously mid-cycle while vec=4 (in SETTLE):
  - all outputs 0 immediately, state IDLE;
  - after release, start -> full clean sweep, pass=1.
- start re-pulsed while busy at vec=2 -> ignored; done timing unchanged (24 cycles from first start).
- WIDTH=2, SETTLE_CYCLES=1, 2-bit ripple of two fa:
  - 32 vectors, done 64 cycles after start, pass=1;
  - swapping carry chain to constant 0 -> first_fail=3 ({a=00,b=01,ci=1}).

Source files
------------

// File: rtl/adder_chk_pkg.sv
// Shared encodings and sizing helpers for the exhaustive adder checker.
package adder_chk_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_SETTLE = S_SETTLE,
    ST_CHECK  = S_CHECK,
    ST_DONE   = S_DONE
  } state_e;

  // Vector is {a, b, ci}.
  function automatic int unsigned vec_width(input int unsigned width);
    return 2 * width + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Combinational golden adder: {co, s} = a + b + ci in WIDTH+1 bits.
module adder_ref_model #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic [WIDTH-1:0] o_s_c,
  output logic             o_co_c
);

  assign {o_co_c, o_s_c} = (WIDTH+1)'(i_a) + (WIDTH+1)'(i_b) + (WIDTH+1)'(i_ci);

endmodule

// File: rtl/adder_exhaustive_checker.sv
// Sweeps every {a,b,ci} into an external adder, waits a settle time, samples
// the sum/carry and tallies mismatches against the golden model.
module adder_exhaustive_checker
  import adder_chk_pkg::*;
#(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               ci,
  input  logic [WIDTH-1:0]   dut_s,
  input  logic               dut_co,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH+1:0] err_count,
  output logic [2*WIDTH:0]   first_fail
);

  localparam int unsigned VW = vec_width(WIDTH);
  localparam int unsigned CW = cnt_width(SETTLE_CYCLES);
  localparam logic [VW-1:0] VEC_LAST = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  state_e          r_state;
  logic [VW-1:0]   r_vec;
  logic [CW-1:0]   r_cnt;
  logic [VW:0]     r_err;
  logic [VW-1:0]   r_first;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;

  logic [WIDTH-1:0] w_ref_s;
  logic             w_ref_co;
  logic             w_mismatch;
  logic [VW:0]      w_err_next;

  adder_ref_model #(.WIDTH(WIDTH)) u_ref (
    .i_a    (r_vec[VW-1:WIDTH+1]),
    .i_b    (r_vec[WIDTH:1]),
    .i_ci   (r_vec[0]),
    .o_s_c  (w_ref_s),
    .o_co_c (w_ref_co)
  );

  assign w_mismatch = ({dut_co, dut_s} != {w_ref_co, w_ref_s});
  assign w_err_next = r_err + (VW+1)'(w_mismatch);

  // Sweep sequencer; DUT response is only consumed in CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_first <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_SETTLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_CHECK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && (r_err == '0)) begin
            r_first <= r_vec;
          end
          if (r_vec == VEC_LAST) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_vec   <= r_vec + VW'(1);
            r_state <= ST_SETTLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign a          = r_vec[VW-1:WIDTH+1];
  assign b          = r_vec[WIDTH:1];
  assign ci         = r_vec[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign first_fail = r_first;

endmodule

// File: tb/tb_adder_exhaustive_checker.sv
// Bench for the exhaustive adder checker: behavioural adder stubs with
// injectable faults, expected tallies derived by enumerating all vectors.
module tb_adder_exhaustive_checker;

  localparam int W1 = 1, S1 = 2, NV1 = 8;
  localparam int W2 = 2, S2 = 1, NV2 = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance 1: single full adder
  logic          start1 = 1'b0;
  logic [W1-1:0] a1, b1, s1;
  logic          ci1, co1, busy1, done1, pass1;
  logic [3:0]    err1;
  logic [2:0]    ff1;
  int            mode1 = 0;
  logic [1:0]    corrupt1 [NV1];

  // Instance 2: 2-bit ripple of two full adders
  logic          start2 = 1'b0;
  logic [W2-1:0] a2, b2, s2;
  logic          ci2, co2, busy2, done2, pass2;
  logic [5:0]    err2;
  logic [4:0]    ff2;
  int            mode2 = 0;

  // Stub fa: mode 1 carry stuck 0, 2 sum inverted, 3 xor with a per-vector mask.
  function automatic logic [1:0] fa_stub(input int mode, input logic a, input logic b,
                                         input logic c, input logic [1:0] mask);
    logic [1:0] r;
    r = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    case (mode)
      1: r[1] = 1'b0;
      2: r[0] = ~r[0];
      3: r = r ^ mask;
      default: ;
    endcase
    return r;
  endfunction

  // Stub ripple: mode 1 cuts the carry between the two stages.
  function automatic logic [2:0] rip_stub(input int mode, input logic [1:0] a,
                                          input logic [1:0] b, input logic c);
    logic [1:0] lo, hi;
    logic       cmid;
    lo   = fa_stub(0, a[0], b[0], c, 2'b00);
    cmid = (mode == 1) ? 1'b0 : lo[1];
    hi   = fa_stub(0, a[1], b[1], cmid, 2'b00);
    return {hi[1], hi[0], lo[0]};
  endfunction

  for (genvar g = 0; g < 1; g++) begin : g_stubs
    assign {co1, s1} = fa_stub(mode1, a1[0], b1[0], ci1, corrupt1[{a1, b1, ci1}]);
    assign {co2, s2} = rip_stub(mode2, a2, b2, ci2);
  end

  adder_exhaustive_checker #(.WIDTH(W1), .SETTLE_CYCLES(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .ci(ci1), .dut_s(s1), .dut_co(co1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1)
  );

  adder_exhaustive_checker #(.WIDTH(W2), .SETTLE_CYCLES(S2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .a(a2), .b(b2), .ci(ci2), .dut_s(s2), .dut_co(co2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail(ff2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected tally for instance 1, from plain integer addition over all vectors.
  task automatic ref1(input int mode, output int e, output int f);
    e = 0; f = 0;
    for (int v = 0; v < NV1; v++) begin
      int av, bv, cv, gold, obs;
      av = (v >> 2) & 1; bv = (v >> 1) & 1; cv = v & 1;
      gold = av + bv + cv;
      obs  = int'(fa_stub(mode, av[0], bv[0], cv[0], corrupt1[v]));
      if (obs != gold) begin
        if (e == 0) f = v;
        e++;
      end
    end
  endtask

  task automatic ref2(input int mode, output int e, output int f);
    e = 0; f = 0;
    for (int v = 0; v < NV2; v++) begin
      int av, bv, cv, gold, obs;
      av = (v >> 3) & 3; bv = (v >> 1) & 3; cv = v & 1;
      gold = av + bv + cv;
      obs  = int'(rip_stub(mode, av[1:0], bv[1:0], cv[0]));
      if (obs != gold) begin
        if (e == 0) f = v;
        e++;
      end
    end
  endtask

  // One sweep on instance 1; repulse >= 0 re-asserts start when that vector begins.
  task automatic sweep1(input int mode, input int exp_err, input int exp_ff, input int repulse);
    int n;
    mode1 = mode;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    n = 0;
    while (!done1 && n < 200) begin
      chk("busy1", 32'(busy1), 32'(1));
      chk("vec1", 32'({a1, b1, ci1}), 32'(n / (S1 + 1)));
      start1 = (repulse >= 0 && n == repulse * (S1 + 1));
      @(posedge clk); #1; n++;
    end
    start1 = 1'b0;
    chk("latency1", 32'(n), 32'(NV1 * (S1 + 1)));
    chk("busy1_end", 32'(busy1), 32'(0));
    chk("err1", 32'(err1), 32'(exp_err));
    chk("first1", 32'(ff1), 32'(exp_ff));
    chk("pass1", 32'(pass1), 32'(exp_err == 0));
    chk("lastvec1", 32'({a1, b1, ci1}), 32'(NV1 - 1));
  endtask

  task automatic sweep2(input int mode, input int exp_err, input int exp_ff);
    int n;
    mode2 = mode;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    n = 0;
    while (!done2 && n < 400) begin
      chk("vec2", 32'({a2, b2, ci2}), 32'(n / (S2 + 1)));
      @(posedge clk); #1; n++;
    end
    chk("latency2", 32'(n), 32'(NV2 * (S2 + 1)));
    chk("err2", 32'(err2), 32'(exp_err));
    chk("first2", 32'(ff2), 32'(exp_ff));
    chk("pass2", 32'(pass2), 32'(exp_err == 0));
  endtask

  initial begin
    int e, f, n;
    for (int v = 0; v < NV1; v++) corrupt1[v] = 2'b00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy1), 32'(0));
    chk("rst_done", 32'(done1), 32'(0));
    chk("rst_pass", 32'(pass1), 32'(0));
    chk("rst_err", 32'(err1), 32'(0));
    chk("rst_first", 32'(ff1), 32'(0));
    chk("rst_vec", 32'({a1, b1, ci1}), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);

    // Clean fa, then known faults
    sweep1(0, 0, 0, -1);
    sweep1(1, 4, 3, -1);
    ref1(1, e, f);
    chk("ref_stuck_err", 32'(e), 32'(4));
    sweep1(2, 8, 0, -1);
    sweep1(0, 0, 0, -1);

    // start while busy is ignored
    sweep1(0, 0, 0, 2);

    // Randomised fault masks
    for (int it = 0; it < 4; it++) begin
      for (int v = 0; v < NV1; v++)
        corrupt1[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ref1(3, e, f);
      sweep1(3, e, f, -1);
    end
    for (int v = 0; v < NV1; v++) corrupt1[v] = 2'b00;

    // Async reset mid-sweep while vector 4 settles
    mode1 = 0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (4 * (S1 + 1)) @(posedge clk);
    #3;
    chk("mid_vec", 32'({a1, b1, ci1}), 32'(4));
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy1), 32'(0));
    chk("arst_done", 32'(done1), 32'(0));
    chk("arst_err", 32'(err1), 32'(0));
    chk("arst_vec", 32'({a1, b1, ci1}), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    sweep1(0, 0, 0, -1);

    // start held high: one DONE cycle then an automatic restart
    @(negedge clk); start1 = 1'b1;
    n = 0;
    @(posedge clk); #1;
    while (!done1 && n < 200) begin @(posedge clk); #1; n++; end
    chk("held_done", 32'(done1), 32'(1));
    @(posedge clk); #1;
    chk("held_restart_done", 32'(done1), 32'(0));
    chk("held_restart_busy", 32'(busy1), 32'(1));
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 200) begin @(posedge clk); #1; n++; end
    chk("held_pass", 32'(pass1), 32'(1));

    // 2-bit ripple, clean and with the carry chain cut
    sweep2(0, 0, 0);
    ref2(1, e, f);
    chk("ref_ripple_first", 32'(f), 32'(3));
    sweep2(1, e, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
